// File: rtl/stack_pkg.sv
// stack_pkg: shared op encoding, request FSM states and default stack geometry
package stack_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 255;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/stack_req_ctrl.sv
// stack_req_ctrl: valid/ready request front-end driving a push-down stack.
// Optional macro STACK_REQ_FLAGCHK_EN also rejects on the stack's own full/empty flags.
module stack_req_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int POP_LAT = 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              stk_en,
    output logic              stk_pushpop,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    input  logic              stk_empty,
    input  logic              stk_full,
    output logic [CW-1:0]     count
);
    state_t      r_state, w_state;
    logic [2:0]  r_wait, w_wait;
    logic        w_acc, w_reject;

    // req_ready is only ever high in IDLE, so it alone qualifies acceptance
    assign w_acc = req_valid && req_ready;

`ifdef STACK_REQ_FLAGCHK_EN
    assign w_reject = (req_op == OP_POP) ? (count == CW'(0) || stk_empty)
                                         : (count == CW'(DEPTH) || stk_full);
`else
    logic w_unused_flags;
    assign w_unused_flags = stk_empty ^ stk_full;
    assign w_reject = (req_op == OP_POP) ? (count == CW'(0)) : (count == CW'(DEPTH));
`endif

    // next-state and pop-latency counter
    always_comb begin
        w_state = r_state;
        w_wait  = r_wait;
        case (r_state)
            IDLE:    w_state = w_acc ? (w_reject ? RESP : ISSUE) : IDLE;
            ISSUE: begin
                w_state = (stk_pushpop == OP_POP) ? WAIT : RESP;
                w_wait  = 3'd0;
            end
            WAIT: begin
                w_state = (r_wait == 3'(POP_LAT - 1)) ? RESP : WAIT;
                w_wait  = r_wait + 3'd1;
            end
            RESP:    w_state = rsp_ready ? IDLE : RESP;
            default: w_state = IDLE;
        endcase
    end

    // state plus every output registered from the next state
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IDLE;
            r_wait      <= 3'd0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            stk_en      <= 1'b0;
            stk_pushpop <= 1'b0;
            stk_wdata   <= '0;
            count       <= '0;
        end else begin
            r_state     <= w_state;
            r_wait      <= w_wait;
            req_ready   <= (w_state == IDLE);
            rsp_valid   <= (w_state == RESP);
            stk_en      <= (w_state == ISSUE);
            stk_pushpop <= w_acc ? req_op : stk_pushpop;
            stk_wdata   <= w_acc ? req_data : stk_wdata;
            rsp_err     <= w_acc ? w_reject : rsp_err;
            rsp_data    <= (w_acc && w_reject) ? '0 :
                           (r_state == ISSUE && stk_pushpop == OP_PUSH) ? stk_wdata :
                           (r_state == WAIT && w_state == RESP) ? stk_rdata : rsp_data;
            count       <= (r_state != ISSUE) ? count :
                           (stk_pushpop == OP_POP) ? count - CW'(1) : count + CW'(1);
        end
    end
endmodule

// File: tb/tb_stack_req_ctrl.sv
// tb_stack_req_ctrl: queue-based reference model plus directed requests for stack_req_ctrl
module tb_stack_req_ctrl;
    import stack_pkg::*;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int POP_LAT = 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic          Clk, Rst, req_valid, req_ready, req_op, rsp_valid, rsp_ready, rsp_err;
    logic          stk_en, stk_pushpop, stk_empty, stk_full;
    logic [DW-1:0] req_data, rsp_data, stk_wdata, stk_rdata;
    logic [CW-1:0] count;

    stack_req_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .POP_LAT(POP_LAT)) dut (
        .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .stk_en(stk_en), .stk_pushpop(stk_pushpop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full), .count(count)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    // behavioural stack with POP_LAT-deep read pipeline
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pipe [POP_LAT];
    int sp;
    assign stk_empty = (sp == 0);
    assign stk_full  = (sp == DEPTH);
    assign stk_rdata = pipe[POP_LAT-1];
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sp <= 0;
            for (int i = 0; i < POP_LAT; i++) pipe[i] <= '0;
        end else begin
            for (int i = 1; i < POP_LAT; i++) pipe[i] <= pipe[i-1];
            if (stk_en && stk_pushpop == OP_PUSH && sp < DEPTH) begin
                mem[sp] <= stk_wdata;
                sp <= sp + 1;
            end else if (stk_en && stk_pushpop == OP_POP && sp > 0) begin
                pipe[0] <= mem[sp-1];
                sp <= sp - 1;
            end
        end
    end

    int total = 0, bad = 0;
    bit chk_on = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, x);
        end
    endtask

    // reference model: one request in flight, stack contents as a queue
    logic [DW-1:0] m_q[$];
    int  e = 0, acc = 0, rsp_cyc = 0, m_count = 0;
    bit  busy = 0, m_ready = 0, m_err = 0, m_op = 0;
    logic [DW-1:0] m_dat = 0, exp_d = 0;
    initial begin
        forever begin
            @(posedge Clk or negedge Rst);
            if (!Rst) begin
                busy = 0; m_ready = 0; m_count = 0; m_q.delete();
            end else begin
                e++;
                if (busy && e - 1 >= rsp_cyc && rsp_ready) busy = 0;
                if (busy && !m_err && e == acc + 1) m_count = m_op ? m_count - 1 : m_count + 1;
                if (m_ready && req_valid) begin
                    busy = 1; acc = e; m_op = req_op; m_dat = req_data;
                    m_err = req_op ? (m_q.size() == 0) : (m_q.size() == DEPTH);
                    if (m_err) exp_d = 0;
                    else if (req_op) exp_d = m_q.pop_back();
                    else begin
                        exp_d = req_data;
                        m_q.push_back(req_data);
                    end
                    rsp_cyc = m_err ? e : (req_op ? e + 1 + POP_LAT : e + 1);
                end
                m_ready = !busy;
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge Clk);
            if (chk_on && !Rst) begin
                chk("rst_ctl", {req_ready, rsp_valid, stk_en, rsp_err, stk_pushpop}, 0);
                chk("rst_data", {rsp_data, stk_wdata, 5'(count)}, 0);
            end else if (chk_on) begin
                chk("req_ready", req_ready, m_ready);
                chk("stk_en", stk_en, busy && !m_err && e == acc);
                chk("rsp_valid", rsp_valid, busy && e >= rsp_cyc);
                chk("count", count, m_count);
                if (busy && !m_err && e == acc) begin
                    chk("stk_pushpop", stk_pushpop, m_op);
                    chk("stk_wdata", stk_wdata, m_dat);
                end
                if (busy && e >= rsp_cyc) begin
                    chk("rsp_data", rsp_data, exp_d);
                    chk("rsp_err", rsp_err, m_err);
                end
            end
        end
    end

    // issue one request from a falling edge; returns response latency in cycles after acceptance
    task automatic req(input logic op, input logic [DW-1:0] d, output int lat,
                       output logic [DW-1:0] rd, output logic re);
        bit ok = 0;
        int n;
        req_valid = 1; req_op = op; req_data = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1;
            @(negedge Clk);
        end
        req_valid = 0;
        if (!ok) chk("accept_timeout", 0, 1);
        n = e;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1;
            else @(negedge Clk);
        end
        if (!ok) chk("rsp_timeout", 0, 1);
        lat = e - n + 1; rd = rsp_data; re = rsp_err;
        if (rsp_ready) @(negedge Clk);
    endtask

    int lat;
    logic [DW-1:0] rd;
    logic re;
    initial begin
        Rst = 1; req_valid = 0; req_op = 0; req_data = 0; rsp_ready = 1;
        #3 Rst = 0; chk_on = 1;
        repeat (3) @(negedge Clk);
        #2 Rst = 1;
        @(negedge Clk);
        chk("ready_after_rst", req_ready, 1);
        req(OP_POP, 8'h00, lat, rd, re);
        chk("underflow_lat", lat, 1); chk("underflow_err", re, 1);
        chk("underflow_data", rd, 0); chk("underflow_count", count, 0);
        for (int i = 1; i <= 3; i++) begin
            req(OP_PUSH, 8'(i), lat, rd, re);
            chk("push_data", rd, i); chk("push_lat", lat, 2); chk("push_err", re, 0);
        end
        chk("count_3", count, 3);
        for (int i = 3; i >= 1; i--) begin
            req(OP_POP, 8'h00, lat, rd, re);
            chk("pop_data", rd, i); chk("pop_lat", lat, 2 + POP_LAT); chk("pop_err", re, 0);
        end
        chk("count_0", count, 0);
        for (int i = 0; i < 5; i++) begin
            req(OP_PUSH, 8'hA0 + 8'(i), lat, rd, re);
            chk("fill_err", re, (i == 4));
            chk("fill_data", rd, (i == 4) ? 0 : 8'hA0 + i);
        end
        chk("count_full", count, 4);
        for (int i = 3; i >= 0; i--) begin
            req(OP_POP, 8'h00, lat, rd, re);
            chk("drain_data", rd, 8'hA0 + i);
        end
        req(OP_PUSH, 8'h55, lat, rd, re);
        rsp_ready = 0;
        req(OP_POP, 8'h00, lat, rd, re);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("hold_valid", rsp_valid, 1); chk("hold_data", rsp_data, 8'h55);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(negedge Clk);
        chk("release_valid", rsp_valid, 0); chk("release_ready", req_ready, 1);
        req(OP_PUSH, 8'h77, lat, rd, re);
        req(OP_PUSH, 8'h78, lat, rd, re);
        req_valid = 1; req_op = OP_POP;
        chk("wait_acc_ready", req_ready, 1);
        @(negedge Clk);
        req_valid = 0;
        @(negedge Clk);
        chk("wait_count", count, 1);
        #2 Rst = 0;
        #1;
        chk("abort_en", stk_en, 0); chk("abort_valid", rsp_valid, 0);
        chk("abort_count", count, 0); chk("abort_ready", req_ready, 0);
        @(negedge Clk);
        #2 Rst = 1;
        @(negedge Clk);
        chk("post_abort_ready", req_ready, 1);
        repeat (4) begin
            @(negedge Clk);
            chk("no_stale_rsp", rsp_valid, 0);
        end
        req(OP_PUSH, 8'h09, lat, rd, re);
        chk("post_abort_push", rd, 8'h09); chk("post_abort_count", count, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
